eight_bit_adder: RTL and testbench
==================================

# eight_bit_adder

Registered 8-bit unsigned binary adder. Adds two 8-bit operands with no carry-in and produces an 8-bit sum plus a carry-out, captured in output registers on the rising clock edge. It serves as a basic arithmetic leaf block for datapaths that need a one-cycle, fully registered add.

## Interface
Parameters:
- none; the operand width is fixed at 8 by the package constant `ADDER_W` = 8.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- i1  input  8  operand A, unsigned
- i2  input  8  operand B, unsigned
- s  output  8  registered sum bits [7:0]
- cout  output  1  registered carry-out (bit 8 of the sum)

## Operation
- Compute {cout, s} = i1 + i2 as a 9-bit unsigned result, using zero-extended operands.
- There is no carry-in. The internal ripple chain starts with carry 0.
- Sum overflow is never flagged separately. cout is the only overflow indication.
- The result wraps modulo 256 in s. For example, 0xFF + 0x01 gives s = 0x00 and cout = 1.
- There is no signed interpretation and no handshake. Every cycle produces a new result.

## Timing
- i1 and i2 are sampled at each rising clk edge while rst_n = 1.
- s and cout update at that same edge. Latency is 1 cycle and throughput is 1 result per cycle.
- Inputs must be stable for setup/hold around the rising edge. The combinational path from input to register is the full 8-stage ripple chain.
- Reset values: s = 8'h00 and cout = 0.
- Assertion of rst_n = 0 clears the outputs immediately, independent of clk.
- Reset mid-operation: any in-flight result is discarded. The first valid result appears at the first rising edge after rst_n deasserts, and reflects the inputs present at that edge.
- Inputs that change between edges have no effect on the outputs until the next edge.

## Structure
- Shared package `adder_pkg`: holds constant `ADDER_W` = 8.
- Sub-module `full_adder` has inputs a, b, ci and outputs sum, co:
  - sum = a ^ b ^ ci
  - co = (a & b) | (ci & (a ^ b))
- The top level instantiates 8 `full_adder`s as a ripple-carry chain:
  - carry[0] = 0
  - carry[i+1] = co of stage i
  - the stage-7 co drives the cout register
- The output register is a single always block with asynchronous reset on negedge rst_n.

## Test plan
- Reset: hold rst_n = 0 with i1 = 0xFF and i2 = 0xFF. Require s = 0x00 and cout = 0 both during reset and without any clock edge.
- 8'b11000011 + 8'b11001011 (195 + 203): after 1 edge, require s = 8'b10001110 and cout = 1.
- 8'b01000011 + 8'b10000011 (67 + 131): require s = 8'b11000110 and cout = 0.
- 8'b01000000 + 8'b11000000 (64 + 192): require s = 8'b00000000 and cout = 1 (exact wrap).
- Boundaries:
  - 8'b11111111 + 8'b00000000 must give s = 8'b11111111 and cout = 0.
  - 8'b00000010 + 8'b01111111 must give s = 8'b10000001 and cout = 0.
- Back-to-back and reset mid-stream:
  - Apply a new vector every cycle and require each result exactly one edge later.
  - Assert rst_n low between edges and require the outputs to clear at once.
  - After release, require the first result at the next edge.

Source files
------------

// File: rtl/adder_pkg.sv
// Purpose: shared constants for the registered ripple-carry adder.
// Latency: n/a (constants only).
// Backpressure: n/a.
package adder_pkg;

  // Operand width; the adder is built for exactly this many bits.
  localparam int ADDER_W = 8;

endpackage : adder_pkg

// File: rtl/eight_bit_adder_full_adder.sv
// Purpose: single-bit full adder, one stage of the ripple chain.
// Latency: combinational.
// Backpressure: none.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic sum,
  output logic co
);

  logic half_sum;

  // Propagate term is shared by the sum and the carry.
  always_comb begin
    half_sum = a ^ b;
    sum      = half_sum ^ ci;
    co       = (a & b) | (ci & half_sum);
  end

endmodule : full_adder

// File: rtl/eight_bit_adder.sv
// Purpose: 8-bit unsigned adder, ripple-carry, with registered sum and carry-out.
// Latency: 1 cycle, one result per cycle.
// Backpressure: none; a new result is captured on every rising edge.
module eight_bit_adder
  import adder_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [ADDER_W-1:0] i1,
  input  logic [ADDER_W-1:0] i2,
  output logic [ADDER_W-1:0] s,
  output logic               cout
);

  // carry[i] feeds stage i; carry[ADDER_W] is the final carry-out.
  logic [ADDER_W:0]   carry;
  logic [ADDER_W-1:0] sum_comb;

  // There is no carry-in, so the chain starts at zero.
  assign carry[0] = 1'b0;

  for (genvar g = 0; g < ADDER_W; g++) begin : g_stage
    full_adder u_fa (
      .a   (i1[g]),
      .b   (i2[g]),
      .ci  (carry[g]),
      .sum (sum_comb[g]),
      .co  (carry[g+1])
    );
  end

  // Capture the ripple result; reset clears the outputs without waiting for a clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s    <= '0;
      cout <= 1'b0;
    end else begin
      s    <= sum_comb;
      cout <= carry[ADDER_W];
    end
  end

endmodule : eight_bit_adder

// File: tb/tb_eight_bit_adder.sv
// Purpose: randomized plus directed scoreboard bench for eight_bit_adder.
// Latency: expects each result exactly one rising edge after its operands.
// Backpressure: none; operands are driven every cycle.
module tb_eight_bit_adder;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] i1    = 8'h00;
  logic [7:0] i2    = 8'h00;
  logic [7:0] s;
  logic       cout;

  int checks   = 0;
  int failures = 0;

  // Expected {cout, s} values in issue order.
  logic [8:0] sb_q[$];
  logic [8:0] exp_v;

  eight_bit_adder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .i1    (i1),
    .i2    (i2),
    .s     (s),
    .cout  (cout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [8:0] act, input logic [8:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: plain 9-bit unsigned addition of zero-extended operands.
  function automatic logic [8:0] model(input logic [7:0] a, input logic [7:0] b);
    int unsigned total;
    total = int'(a) + int'(b);
    return total[8:0];
  endfunction

  // Drive one operand pair for the coming edge and record what it must produce.
  task automatic apply(input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    i1 = a;
    i2 = b;
    sb_q.push_back(model(a, b));
  endtask

  // Monitor: every edge taken out of reset consumes the oldest expectation.
  always @(posedge clk) begin
    if (rst_n && sb_q.size() > 0) begin
      exp_v = sb_q.pop_front();
      #1;
      check("result", {cout, s}, exp_v);
    end
  end

  initial begin
    logic [8:0] last;

    // Reset with all-ones operands: outputs clear before any clock edge.
    i1    = 8'hFF;
    i2    = 8'hFF;
    rst_n = 1'b0;
    #1;
    check("reset_no_edge", {cout, s}, 9'h000);
    repeat (2) @(posedge clk);
    #1;
    check("reset_held", {cout, s}, 9'h000);

    // Release at a falling edge with the first vector already in place.
    @(negedge clk);
    i1 = 8'b11000011;
    i2 = 8'b11001011;
    sb_q.push_back(9'b1_10001110);
    rst_n = 1'b1;

    // Directed vectors, expected values written out literally.
    @(negedge clk);
    i1 = 8'b01000011; i2 = 8'b10000011; sb_q.push_back(9'b0_11000110);
    @(negedge clk);
    i1 = 8'b01000000; i2 = 8'b11000000; sb_q.push_back(9'b1_00000000);
    @(negedge clk);
    i1 = 8'b11111111; i2 = 8'b00000000; sb_q.push_back(9'b0_11111111);
    @(negedge clk);
    i1 = 8'b00000010; i2 = 8'b01111111; sb_q.push_back(9'b0_10000001);
    @(negedge clk);
    i1 = 8'hFF; i2 = 8'h01; sb_q.push_back(9'b1_00000000);
    apply(8'hFF, 8'hFF);
    apply(8'h00, 8'h00);

    // Inputs changing between edges must not disturb the registered result.
    apply(8'h5A, 8'h3C);
    last = model(8'h5A, 8'h3C);
    @(posedge clk);
    #3;
    i1 = 8'hA5;
    i2 = 8'hC3;
    #1;
    check("hold_between_edges", {cout, s}, last);

    // Back-to-back random vectors.
    for (int k = 0; k < 200; k++) begin
      apply(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    // Reset asserted between edges clears outputs at once.
    @(posedge clk);
    #3;
    i1    = 8'h80;
    i2    = 8'h80;
    rst_n = 1'b0;
    #1;
    check("mid_reset_clear", {cout, s}, 9'h000);
    @(posedge clk);
    #1;
    check("mid_reset_edge", {cout, s}, 9'h000);

    // First result after release appears at the very next edge.
    @(negedge clk);
    i1 = 8'h7F;
    i2 = 8'h81;
    sb_q.push_back(model(8'h7F, 8'h81));
    rst_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      apply(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end

    // Drain the scoreboard within a bounded number of edges.
    for (int k = 0; k < 10 && sb_q.size() > 0; k++) begin
      @(posedge clk);
    end
    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL drain actual=%0d pending required=0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_eight_bit_adder
